// File: rtl/spdif_rx.sv
// S/PDIF (IEC 60958) receiver on a free-running clock: biphase-mark decode, preamble order and parity checks, lock tracking.
// Latency: strobe (or parity error) is high 4 cycles after the line edge that terminates slot 31.
// Backpressure: none; the consumer must accept every one-cycle strobe.
module spdif_rx #(
    parameter int UI_CYCLES  = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spdif_i,
    output logic [23:0] sample_o,
    output logic        sample_valid_o,
    output logic        right_o,
    output logic        block_start_o,
    output logic        validity_o,
    output logic        user_o,
    output logic        cstat_o,
    output logic        parity_err_o,
    output logic        lock_o
);
    localparam int HALF = UI_CYCLES / 2;
    localparam int SAT  = 4 * UI_CYCLES;
    localparam int CW   = $clog2(SAT + 1);
    localparam int LW   = $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0] SAT_C  = CW'(SAT);
    localparam logic [CW-1:0] T1_C   = CW'(UI_CYCLES + HALF);
    localparam logic [CW-1:0] T2_C   = CW'(2 * UI_CYCLES + HALF);
    localparam logic [CW-1:0] T3_C   = CW'(3 * UI_CYCLES + HALF);
    localparam logic [LW-1:0] LOCK_C = LW'(LOCK_COUNT);

    typedef enum logic [1:0] {CL_1, CL_2, CL_3, CL_LONG} cls_t;
    typedef enum logic [1:0] {ST_HUNT, ST_PRE, ST_DATA} state_t;

    logic          sync1_q, sync2_q, prev_q, edge_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_fired_q, to_fired_d, timeout;

    state_t        state_q;
    logic [1:0]    pre_idx_q;
    cls_t          cls0_q, cls1_q;
    logic          is_w_q, is_b_q, seq_ok_q;
    logic          prev_vld_q, prev_w_q;
    logic          half_q;
    logic [4:0]    bit_idx_q;
    logic [26:0]   sr_q;
    logic          par_q;
    logic [LW-1:0] good_q;

    cls_t          cls;
    logic          pre_b, pre_m, pre_w, seq_bad;
    logic          dec_err, data_3ui, bit_vld, bit_val, par_next;
    logic [LW-1:0] good_inc;

    // Two-flop synchroniser followed by a registered any-polarity edge detector
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= spdif_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q ^ prev_q;
        end
    end

    // Interval counter: reloads to 1 on an edge so its value at the next edge is the interval; timeout fires once on saturation
    always_comb begin
        cnt_d      = cnt_q;
        to_fired_d = to_fired_q;
        timeout    = 1'b0;
        if (edge_q) begin
            cnt_d      = CW'(1);
            to_fired_d = 1'b0;
        end else if (cnt_q != SAT_C) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!to_fired_q) begin
            timeout    = 1'b1;
            to_fired_d = 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            to_fired_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            to_fired_q <= to_fired_d;
        end
    end

    // Interval classification, preamble matching and per-edge error decode
    always_comb begin
        if (cnt_q < T1_C)      cls = CL_1;
        else if (cnt_q < T2_C) cls = CL_2;
        else if (cnt_q < T3_C) cls = CL_3;
        else                   cls = CL_LONG;

        // Preamble intervals following the leading 3 UI pulse
        pre_b   = (cls0_q == CL_1) && (cls1_q == CL_1) && (cls == CL_3);
        pre_m   = (cls0_q == CL_3) && (cls1_q == CL_1) && (cls == CL_1);
        pre_w   = (cls0_q == CL_2) && (cls1_q == CL_1) && (cls == CL_2);
        seq_bad = prev_vld_q && (prev_w_q == pre_w);

        dec_err  = 1'b0;
        data_3ui = 1'b0;
        if (edge_q) begin
            if (state_q == ST_PRE) begin
                if (pre_idx_q == 2'd0 && cls != CL_3) dec_err = 1'b1;
                if (pre_idx_q == 2'd3 && !(pre_b || pre_m || pre_w)) dec_err = 1'b1;
            end else if (state_q == ST_DATA) begin
                if (cls == CL_LONG || (cls == CL_2 && half_q)) dec_err = 1'b1;
                if (cls == CL_3) data_3ui = 1'b1;
            end
        end

        bit_vld  = edge_q && (state_q == ST_DATA) &&
                   ((cls == CL_1 && half_q) || (cls == CL_2 && !half_q));
        bit_val  = (cls == CL_1);
        par_next = par_q ^ bit_val;
        good_inc = (good_q == LOCK_C) ? good_q : good_q + 1'b1;
    end

    // Framing FSM with registered outputs. pre_idx 0 waits for the leading 3 UI pulse
    // (entered after slot 31); HUNT and the in-data 3 UI case have already consumed it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_HUNT;
            pre_idx_q      <= 2'd0;
            cls0_q         <= CL_1;
            cls1_q         <= CL_1;
            is_w_q         <= 1'b0;
            is_b_q         <= 1'b0;
            seq_ok_q       <= 1'b0;
            prev_vld_q     <= 1'b0;
            prev_w_q       <= 1'b0;
            half_q         <= 1'b0;
            bit_idx_q      <= 5'd0;
            sr_q           <= '0;
            par_q          <= 1'b0;
            good_q         <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            right_o        <= 1'b0;
            block_start_o  <= 1'b0;
            validity_o     <= 1'b0;
            user_o         <= 1'b0;
            cstat_o        <= 1'b0;
            parity_err_o   <= 1'b0;
            lock_o         <= 1'b0;
        end else begin
            sample_valid_o <= 1'b0;
            parity_err_o   <= 1'b0;
            if (timeout || dec_err) begin
                state_q    <= ST_HUNT;
                prev_vld_q <= 1'b0;
                good_q     <= '0;
                lock_o     <= 1'b0;
            end else if (data_3ui) begin
                state_q    <= ST_PRE;
                pre_idx_q  <= 2'd1;
                prev_vld_q <= 1'b0;
                good_q     <= '0;
                lock_o     <= 1'b0;
            end else if (edge_q) begin
                case (state_q)
                    ST_HUNT: begin
                        if (cls == CL_3) begin
                            state_q   <= ST_PRE;
                            pre_idx_q <= 2'd1;
                        end
                    end
                    ST_PRE: begin
                        case (pre_idx_q)
                            2'd0: pre_idx_q <= 2'd1;
                            2'd1: begin
                                cls0_q    <= cls;
                                pre_idx_q <= 2'd2;
                            end
                            2'd2: begin
                                cls1_q    <= cls;
                                pre_idx_q <= 2'd3;
                            end
                            default: begin
                                is_w_q     <= pre_w;
                                is_b_q     <= pre_b;
                                seq_ok_q   <= !seq_bad;
                                prev_vld_q <= 1'b1;
                                prev_w_q   <= pre_w;
                                if (seq_bad) begin
                                    good_q <= '0;
                                    lock_o <= 1'b0;
                                end
                                sr_q      <= '0;
                                par_q     <= 1'b0;
                                half_q    <= 1'b0;
                                bit_idx_q <= 5'd4;
                                state_q   <= ST_DATA;
                            end
                        endcase
                    end
                    ST_DATA: begin
                        if (cls == CL_1 && !half_q) begin
                            half_q <= 1'b1;
                        end else if (bit_vld) begin
                            half_q <= 1'b0;
                            par_q  <= par_next;
                            if (bit_idx_q == 5'd31) begin
                                state_q   <= ST_PRE;
                                pre_idx_q <= 2'd0;
                                if (!par_next) begin
                                    sample_valid_o <= 1'b1;
                                    sample_o       <= sr_q[23:0];
                                    validity_o     <= sr_q[24];
                                    user_o         <= sr_q[25];
                                    cstat_o        <= sr_q[26];
                                    right_o        <= is_w_q;
                                    block_start_o  <= is_b_q;
                                    if (seq_ok_q) begin
                                        good_q <= good_inc;
                                        lock_o <= (good_inc == LOCK_C);
                                    end
                                end else begin
                                    parity_err_o <= 1'b1;
                                    good_q       <= '0;
                                    lock_o       <= 1'b0;
                                end
                            end else begin
                                sr_q      <= {bit_val, sr_q[26:1]};
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end
endmodule
